// File: rtl/sig_dump_pkg.sv
// Shared types and constants for the signature dump engine.
// The optional CRC trailer is enabled by defining SIG_DUMP_CRC_EN.
package sig_dump_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int CNT_W_DEF  = 16;

  localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RD    = 3'd2,
    ST_CAP   = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // The CRC is processed LSB-first, so the sub-module works with the bit-reversed polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/sig_dump_engine_if.sv
// Bundles the control, TCM read port, signature stream and status signals of sig_dump_engine.
// master = engine side, slave = CSR/memory/sink side.
interface sig_dump_engine_if
  import sig_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic              finish_i;
  logic [ADDR_W-1:0] begin_addr_i;
  logic [ADDR_W-1:0] end_addr_i;

  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_rdata_i;

  logic              sig_valid_o;
  logic [31:0]       sig_data_o;
  logic              sig_ready_i;

  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [CNT_W-1:0]  word_count_o;

  modport master (
    input  finish_i, begin_addr_i, end_addr_i, mem_rdata_i, sig_ready_i,
    output mem_rd_o, mem_addr_o, sig_valid_o, sig_data_o,
           busy_o, done_o, err_o, word_count_o
  );

  modport slave (
    output finish_i, begin_addr_i, end_addr_i, mem_rdata_i, sig_ready_i,
    input  mem_rd_o, mem_addr_o, sig_valid_o, sig_data_o,
           busy_o, done_o, err_o, word_count_o
  );

endinterface

// File: rtl/sig_dump_crc32.sv
// One-word combinational update of the reflected CRC-32; bytes are consumed little-endian,
// which for a reflected CRC is simply data bit 0 first.
module sig_dump_crc32
  import sig_dump_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ POLY_R;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/sig_dump_engine.sv
// Streams the test signature region [begin, end) out of the TCM, one word per >=3 cycles.
// Define SIG_DUMP_CRC_EN to append an uncounted CRC-32 word after the data words.
module sig_dump_engine
  import sig_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic                clk_i,
  input logic                rst_i,
  sig_dump_engine_if.master  bus
);

  state_e            state;
  logic              finish_q;
  logic [ADDR_W-1:0] begin_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              sig_valid;
  logic [31:0]       sig_data;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  word_count;

  logic              finish_rise;
  logic [ADDR_W-1:0] next_addr;
  logic              range_bad;

  assign finish_rise = bus.finish_i & ~finish_q;
  assign next_addr   = cur_addr + ADDR_W'(4);
  assign range_bad   = (begin_q[1:0] != 2'b00) || (end_q[1:0] != 2'b00) || (begin_q > end_q);

`ifdef SIG_DUMP_CRC_EN
  logic [31:0] crc_q;
  logic [31:0] crc_next;
  logic        crc_phase;

  sig_dump_crc32 u_crc (
    .crc_in  (crc_q),
    .data    (sig_data),
    .crc_out (crc_next)
  );
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      finish_q   <= 1'b0;
      begin_q    <= '0;
      end_q      <= '0;
      cur_addr   <= '0;
      sig_valid  <= 1'b0;
      sig_data   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
`ifdef SIG_DUMP_CRC_EN
      crc_q      <= CRC_INIT;
      crc_phase  <= 1'b0;
`endif
    end else begin
      finish_q <= bus.finish_i;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (finish_rise) begin
            begin_q    <= bus.begin_addr_i;
            end_q      <= bus.end_addr_i;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef SIG_DUMP_CRC_EN
            crc_q      <= CRC_INIT;
            crc_phase  <= 1'b0;
`endif
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (range_bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (begin_q == end_q) begin
`ifdef SIG_DUMP_CRC_EN
            sig_data  <= crc_q ^ CRC_XOROUT;
            sig_valid <= 1'b1;
            crc_phase <= 1'b1;
            state     <= ST_OUT;
`else
            done  <= 1'b1;
            state <= ST_DONE;
`endif
          end else begin
            cur_addr <= begin_q;
            state    <= ST_RD;
          end
        end
        ST_RD: state <= ST_CAP;
        ST_CAP: begin
          sig_data  <= bus.mem_rdata_i;
          sig_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.sig_ready_i) begin
`ifdef SIG_DUMP_CRC_EN
            if (crc_phase) begin
              sig_valid <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              if (word_count != '1) word_count <= word_count + CNT_W'(1);
              cur_addr <= next_addr;
              crc_q    <= crc_next;
              // Last data word: the trailer goes out back-to-back, so valid stays high.
              if (next_addr == end_q) begin
                sig_data  <= crc_next ^ CRC_XOROUT;
                crc_phase <= 1'b1;
              end else begin
                sig_valid <= 1'b0;
                state     <= ST_RD;
              end
            end
`else
            sig_valid <= 1'b0;
            if (word_count != '1) word_count <= word_count + CNT_W'(1);
            cur_addr <= next_addr;
            if (next_addr == end_q) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_RD;
            end
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_o     = (state == ST_RD);
  assign bus.mem_addr_o   = (state == ST_RD) ? cur_addr : '0;
  assign bus.sig_valid_o  = sig_valid;
  assign bus.sig_data_o   = sig_data;
  assign bus.busy_o       = (state == ST_CHECK) || (state == ST_RD) ||
                            (state == ST_CAP)   || (state == ST_OUT);
  assign bus.done_o       = done;
  assign bus.err_o        = err;
  assign bus.word_count_o = word_count;

endmodule

// File: tb/tb_sig_dump_engine.sv
// Directed, table-driven bench for sig_dump_engine, with hand sequences for reset abort
// and mid-dump finish pulses. Builds with or without SIG_DUMP_CRC_EN.
module tb_sig_dump_engine;

  localparam int AW = 17;
  localparam int CW = 16;
`ifdef SIG_DUMP_CRC_EN
  localparam int CRC_WORDS = 1;
`else
  localparam int CRC_WORDS = 0;
`endif

  typedef struct {
    logic [AW-1:0] b;
    logic [AW-1:0] e;
    int            stall;
    int            glitch;
    int            exp_words;
    logic          exp_err;
    int            max_cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sig_dump_engine_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  sig_dump_engine #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0]   mem [0:1023];
  logic [31:0]   rx_log[$];
  logic [AW-1:0] rd_log[$];
  int            assert_count = 0;
  int            fail_count   = 0;
  int            stall_cfg    = 0;
  int            wait_cnt     = 0;
  logic          ready_drv    = 1'b0;
  logic          prev_valid   = 1'b0;
  logic          prev_ready   = 1'b0;
  logic [31:0]   prev_data    = '0;

  // Memory model: registered read, data valid the cycle after the strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.mem_rdata_i <= '0;
    else if (bus.mem_rd_o) bus.mem_rdata_i <= mem[bus.mem_addr_o[11:2]];
  end

  // Sink that holds ready low for stall_cfg cycles of every valid word.
  always begin
    @(posedge clk);
    #1;
    if (!bus.sig_valid_o) begin
      wait_cnt  = 0;
      ready_drv = (stall_cfg == 0);
    end else if (wait_cnt >= stall_cfg) begin
      ready_drv = 1'b1;
    end else begin
      ready_drv = 1'b0;
      wait_cnt++;
    end
  end
  assign bus.sig_ready_i = ready_drv;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus.mem_rd_o) rd_log.push_back(bus.mem_addr_o);
      if (bus.sig_valid_o && prev_valid && !prev_ready)
        compare("data_stable", bus.sig_data_o, prev_data);
      if (bus.sig_valid_o && bus.sig_ready_i) rx_log.push_back(bus.sig_data_o);
      prev_valid = bus.sig_valid_o;
      prev_ready = bus.sig_ready_i;
      prev_data  = bus.sig_data_o;
    end
  end

`ifdef SIG_DUMP_CRC_EN
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [31:0] w);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 4; b++) begin
      c = c ^ {24'h0, w[8*b +: 8]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
`endif

  task automatic check_all_zero(input string tag);
    compare({tag, "_busy"},  32'(bus.busy_o),       32'h0);
    compare({tag, "_done"},  32'(bus.done_o),       32'h0);
    compare({tag, "_err"},   32'(bus.err_o),        32'h0);
    compare({tag, "_valid"}, 32'(bus.sig_valid_o),  32'h0);
    compare({tag, "_data"},  bus.sig_data_o,        32'h0);
    compare({tag, "_rd"},    32'(bus.mem_rd_o),     32'h0);
    compare({tag, "_addr"},  32'(bus.mem_addr_o),   32'h0);
    compare({tag, "_count"}, 32'(bus.word_count_o), 32'h0);
  endtask

  // Waits for done_o with a cycle budget; from the second edge on, done reflects this dump.
  task automatic wait_done(input int glitch, output int cycles);
    int n;
    for (n = 1; n <= 5000; n++) begin
      @(posedge clk);
      #1;
      if (glitch != 0 && n == 6) bus.finish_i = 1'b0;
      if (glitch != 0 && n == 8) bus.finish_i = 1'b1;
      if (n >= 2 && bus.done_o) break;
    end
    cycles = n;
    compare("done_timeout", 32'(n <= 5000), 32'h1);
  endtask

  task automatic applyStimulus(input vec_t v, output int cycles);
    @(posedge clk);
    #1;
    bus.finish_i     = 1'b0;
    stall_cfg        = v.stall;
    bus.begin_addr_i = v.b;
    bus.end_addr_i   = v.e;
    @(posedge clk);
    #1;
    bus.finish_i = 1'b1;
    wait_done(v.glitch, cycles);
  endtask

  task automatic checkOutput(input vec_t v, input int rx_base, input int rd_base, input int cycles);
    int n_rx, n_rd, exp_rx;
    logic [31:0] w;
`ifdef SIG_DUMP_CRC_EN
    logic [31:0] c;
    c = 32'hFFFFFFFF;
`endif
    n_rx   = rx_log.size() - rx_base;
    n_rd   = rd_log.size() - rd_base;
    exp_rx = v.exp_err ? 0 : v.exp_words + CRC_WORDS;
    compare("done",       32'(bus.done_o),       32'h1);
    compare("err",        32'(bus.err_o),        32'(v.exp_err));
    compare("busy",       32'(bus.busy_o),       32'h0);
    compare("word_count", 32'(bus.word_count_o), 32'(v.exp_words));
    compare("rd_pulses",  32'(n_rd),             32'(v.exp_words));
    compare("rx_words",   32'(n_rx),             32'(exp_rx));
    if (v.max_cycles > 0) compare("done_latency", 32'(cycles <= v.max_cycles), 32'h1);
    for (int k = 0; k < v.exp_words; k++) begin
      w = mem[10'(v.b[11:2] + 10'(k))];
      if (k < n_rd) compare("rd_addr", 32'(rd_log[rd_base + k]), 32'(v.b + AW'(4 * k)));
      if (k < n_rx) compare("rx_data", rx_log[rx_base + k], w);
`ifdef SIG_DUMP_CRC_EN
      c = crc_step(c, w);
`endif
    end
`ifdef SIG_DUMP_CRC_EN
    if (!v.exp_err)
      compare("crc_word", (n_rx > v.exp_words) ? rx_log[rx_base + v.exp_words] : 32'hDEADBEEF,
              c ^ 32'hFFFFFFFF);
`endif
  endtask

  initial begin
    vec_t        vecs [9];
    logic [31:0] s1 [4];
    int          cycles, rx_base, rd_base, n;

    vecs[0] = '{b: 17'h100, e: 17'h110, stall: 0,  glitch: 0, exp_words: 4, exp_err: 1'b0, max_cycles: 0};
    vecs[1] = '{b: 17'h102, e: 17'h110, stall: 0,  glitch: 0, exp_words: 0, exp_err: 1'b1, max_cycles: 0};
    vecs[2] = '{b: 17'h200, e: 17'h100, stall: 0,  glitch: 0, exp_words: 0, exp_err: 1'b1, max_cycles: 0};
    vecs[3] = '{b: 17'h300, e: 17'h300, stall: 0,  glitch: 0, exp_words: 0, exp_err: 1'b0, max_cycles: 3};
    vecs[4] = '{b: 17'h100, e: 17'h108, stall: 10, glitch: 0, exp_words: 2, exp_err: 1'b0, max_cycles: 0};
    vecs[5] = '{b: 17'h100, e: 17'h111, stall: 0,  glitch: 0, exp_words: 0, exp_err: 1'b1, max_cycles: 0};
    vecs[6] = '{b: 17'h3F8, e: 17'h400, stall: 3,  glitch: 0, exp_words: 2, exp_err: 1'b0, max_cycles: 0};
    vecs[7] = '{b: 17'h100, e: 17'h110, stall: 4,  glitch: 1, exp_words: 4, exp_err: 1'b0, max_cycles: 0};
    vecs[8] = '{b: 17'h380, e: 17'h384, stall: 0,  glitch: 0, exp_words: 1, exp_err: 1'b0, max_cycles: 0};
    s1[0] = 32'h11111111;
    s1[1] = 32'h22222222;
    s1[2] = 32'h33333333;
    s1[3] = 32'h44444444;

    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | 32'(i);
    for (int i = 0; i < 4; i++) mem[10'h40 + 10'(i)] = s1[i];
    mem[10'h0E0] = 32'h00000000;

    rst              = 1'b1;
    bus.finish_i     = 1'b0;
    bus.begin_addr_i = '0;
    bus.end_addr_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      rx_base = rx_log.size();
      rd_base = rd_log.size();
      applyStimulus(vecs[i], cycles);
      checkOutput(vecs[i], rx_base, rd_base, cycles);
    end

`ifdef SIG_DUMP_CRC_EN
    compare("crc_zero_word", (rx_log.size() >= 2) ? rx_log[rx_log.size() - 1] : 32'hDEADBEEF,
            32'h2144DF1C);
`endif

    // Abort during the second word's OUT state, then restart with finish held high.
    @(posedge clk);
    #1;
    bus.finish_i     = 1'b0;
    stall_cfg        = 3;
    bus.begin_addr_i = 17'h100;
    bus.end_addr_i   = 17'h110;
    @(posedge clk);
    #1;
    bus.finish_i = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.word_count_o == 16'd1 && bus.sig_valid_o) break;
    end
    compare("abort_reach_timeout", 32'(n < 200), 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(posedge clk);
    #1;
    check_all_zero("abort_edge");
    rx_base = rx_log.size();
    rd_base = rd_log.size();
    @(negedge clk);
    rst = 1'b0;
    for (n = 0; n < 500; n++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) break;
    end
    compare("restart_timeout", 32'(n < 500), 32'h1);
    compare("restart_count", 32'(bus.word_count_o), 32'd4);
    compare("restart_err",   32'(bus.err_o), 32'h0);
    compare("restart_rd",    32'(rd_log.size() - rd_base), 32'd4);
    compare("restart_rx",    32'(rx_log.size() - rx_base), 32'(4 + CRC_WORDS));
    for (int k = 0; k < 4; k++) begin
      compare("restart_data", (rx_log.size() > rx_base + k) ? rx_log[rx_base + k] : 32'hDEADBEEF, s1[k]);
      compare("restart_addr", (rd_log.size() > rd_base + k) ? 32'(rd_log[rd_base + k]) : 32'hDEADBEEF,
              32'h100 + 32'(4 * k));
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
